// File: rtl/bidir_link_ctrl.sv
// Half-duplex single-wire transaction controller driving a bidir_pin cell:
// preamble + MSB-first command, bus turnaround, then an optional MSB-first response capture.
module bidir_link_ctrl #(
  parameter int WIDTH       = 8,
  parameter int TURN_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             dir,
  output logic             data_out,
  input  logic             data_in
);

  localparam int CNT_MAX = (WIDTH > TURN_CYCLES) ? WIDTH : TURN_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] W_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] T_LAST = CW'(TURN_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, PRE, TX, TURN, RX, DONE} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic [WIDTH-1:0] tx_shift, rx_shift, rx_next;
  logic             rd_flag;
  logic             done_reg, done_next;
  logic             rd_valid_reg, rd_valid_next;
  logic             load, tx_step, rx_step, rd_update;

  assign done     = done_reg;
  assign rd_valid = rd_valid_reg;
  // The bit sampled on the edge that ends RX must land in rd_data on that same edge.
  assign rx_next  = (rx_shift << 1) | WIDTH'(data_in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      done_reg     <= 1'b0;
      rd_valid_reg <= 1'b0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      done_reg     <= done_next;
      rd_valid_reg <= rd_valid_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load       = 1'b0;
    tx_step    = 1'b0;
    rx_step    = 1'b0;
    dir        = 1'b0;
    data_out   = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          load       = 1'b1;
          cnt_next   = '0;
          state_next = PRE;
        end
      end
      PRE: begin
        dir        = 1'b1;
        data_out   = 1'b1;
        cnt_next   = '0;
        state_next = TX;
      end
      TX: begin
        dir      = 1'b1;
        data_out = tx_shift[WIDTH-1];
        tx_step  = 1'b1;
        if (cnt == W_LAST) begin
          cnt_next   = '0;
          state_next = TURN;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      TURN: begin
        if (cnt == T_LAST) begin
          cnt_next   = '0;
          state_next = rd_flag ? RX : DONE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      RX: begin
        rx_step = 1'b1;
        if (cnt == W_LAST) begin
          cnt_next   = '0;
          state_next = DONE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    done_next     = (state_next == DONE);
    rd_valid_next = done_next && rd_flag;
    rd_update     = (state == RX) && (state_next == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift <= '0;
      rx_shift <= '0;
      rd_flag  <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (load) begin
        tx_shift <= wr_data;
        rd_flag  <= rd_en;
        rx_shift <= '0;
      end else if (tx_step) begin
        tx_shift <= tx_shift << 1;
      end
      if (rx_step) begin
        rx_shift <= rx_next;
      end
      if (rd_update) begin
        rd_data <= rx_next;
      end
    end
  end

endmodule

// File: tb/tb_bidir_link_ctrl.sv
// Directed bench for bidir_link_ctrl (WIDTH=8, TURN_CYCLES=2); inputs change and
// outputs are sampled on the falling clock edge.
module tb_bidir_link_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] wr_data;
  logic       rd_en;
  logic       busy;
  logic       done;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       dir;
  logic       data_out;
  logic       data_in;

  int checks = 0;
  int errors = 0;

  bidir_link_ctrl #(.WIDTH(8), .TURN_CYCLES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .busy     (busy),
    .done     (done),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .dir      (dir),
    .data_out (data_out),
    .data_in  (data_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction starting from IDLE; cycle k is sampled at the negedge after edge k-1.
  task automatic txn(input string tag, input logic [7:0] w, input logic rd,
                     input logic [7:0] resp, input logic [7:0] exp_rd, input bit inject);
    int last;
    int ndone;
    logic [8:0] seq;
    last  = rd ? 20 : 12;
    ndone = 0;
    seq   = {1'b1, w};
    wr_data = w;
    rd_en   = rd;
    start   = 1'b1;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start   = 1'b0;
        wr_data = ~w;
        rd_en   = ~rd;
      end
      if (inject && k == 5) begin
        start   = 1'b1;
        wr_data = 8'hFF;
      end
      if (inject && k == 6) start = 1'b0;
      data_in = (rd && k >= 12 && k <= 19) ? resp[19-k] : 1'b0;
      chk($sformatf("%s dir c%0d", tag, k), 32'(dir), 32'(k <= 9));
      chk($sformatf("%s dout c%0d", tag, k), 32'(data_out), (k <= 9) ? 32'(seq[9-k]) : 32'd0);
      chk($sformatf("%s busy c%0d", tag, k), 32'(busy), 32'd1);
      chk($sformatf("%s done c%0d", tag, k), 32'(done), 32'(k == last));
      chk($sformatf("%s rd_valid c%0d", tag, k), 32'(rd_valid), 32'(rd && k == last));
      if (done) ndone++;
      if (k == last || !rd) chk($sformatf("%s rd_data c%0d", tag, k), 32'(rd_data), 32'(exp_rd));
    end
    @(negedge clk);
    data_in = 1'b0;
    if (done) ndone++;
    chk({tag, " done count"}, 32'(ndone), 32'd1);
    chk({tag, " busy after"}, 32'(busy), 32'd0);
    chk({tag, " rd_data after"}, 32'(rd_data), 32'(exp_rd));
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    wr_data = 8'h00;
    rd_en   = 1'b0;
    data_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset dir", 32'(dir), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset rd_valid", 32'(rd_valid), 32'd0);
    chk("reset rd_data", 32'(rd_data), 32'd0);
    chk("reset data_out", 32'(data_out), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle busy", 32'(busy), 32'd0);

    // write-only 0xA5
    txn("wrA5", 8'hA5, 1'b0, 8'h00, 8'h00, 1'b0);
    // read: command 0x0F, response 0x3C
    txn("rd3C", 8'h0F, 1'b1, 8'h3C, 8'h3C, 1'b0);
    // start pulsed mid-transaction with 0xFF is ignored
    txn("ign", 8'h3C, 1'b0, 8'h00, 8'h3C, 1'b1);

    // asynchronous reset in TX cycle 4
    wr_data = 8'hA5;
    rd_en   = 1'b0;
    start   = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre-rst dir", 32'(dir), 32'd1);
    chk("pre-rst busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst dir", 32'(dir), 32'd0);
    chk("async rst busy", 32'(busy), 32'd0);
    chk("async rst data_out", 32'(data_out), 32'd0);
    @(negedge clk);
    chk("rst hold done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-rst done", 32'(done), 32'd0);
    chk("post-rst rd_data", 32'(rd_data), 32'd0);
    txn("wr81", 8'h81, 1'b0, 8'h00, 8'h00, 1'b0);

    // start held high: one IDLE cycle between back-to-back transactions
    wr_data = 8'h01;
    rd_en   = 1'b0;
    start   = 1'b1;
    for (int c = 1; c <= 26; c++) begin
      int pos;
      @(negedge clk);
      pos = (c - 1) % 13 + 1;
      chk($sformatf("held busy c%0d", c), 32'(busy), 32'(pos != 13));
      chk($sformatf("held done c%0d", c), 32'(done), 32'(pos == 12));
      chk($sformatf("held dir c%0d", c), 32'(dir), 32'(pos <= 9));
      if (pos <= 9) chk($sformatf("held dout c%0d", c), 32'(data_out), 32'(pos == 1 || pos == 9));
    end
    start = 1'b0;
    @(negedge clk);
    chk("held stop busy", 32'(busy), 32'd0);

    // read 0x5A then write-only: rd_data must stay 0x5A
    txn("rd5A", 8'h11, 1'b1, 8'h5A, 8'h5A, 1'b0);
    txn("wr33", 8'h33, 1'b0, 8'h00, 8'h5A, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bidir_link_ctrl.md
# bidir_link_ctrl

Half-duplex transaction controller for the far side of the `bidir_pin` tristate cell. It owns the cell's `dir`/`data_out` controls and samples its `data_in`. It serialises a command word onto the shared single-wire line, releases the line for a fixed turnaround, then optionally captures a response word driven by the remote end. It sits between the register/command logic and the `bidir_pin` instance, one controller per pin.

## Interface
Parameters:
- `WIDTH`, default 8: bits per command and response word; must be ≥ 1.
- `TURN_CYCLES`, default 2: bus-turnaround cycles between TX and RX; must be ≥ 1.

Ports:
- `clk`  input  1: single clock; all logic on its rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `start`  input  1: request a transaction; sampled only in IDLE.
- `wr_data`  input  WIDTH: command word; captured when `start` is accepted.
- `rd_en`  input  1: transaction expects a response; captured with `wr_data`.
- `busy`  output  1: high in every state except IDLE.
- `done`  output  1: single-cycle pulse in the DONE state.
- `rd_data`  output  WIDTH: last captured response; holds until the next read completes.
- `rd_valid`  output  1: single-cycle pulse with `done`, only when the captured `rd_en` was 1.
- `dir`  output  1: to `bidir_pin.dir`; 1 means the controller drives the line.
- `data_out`  output  1: to `bidir_pin.data_out`.
- `data_in`  input  1: from `bidir_pin.data_in`.

## Operation
- States: IDLE, PRE, TX, TURN, RX, DONE.
- IDLE:
  - `dir`=0, `data_out`=0.
  - `start`=1 captures `wr_data` into a shift register and `rd_en` into a flag, then moves to PRE.
- PRE, 1 cycle: `dir`=1, `data_out`=1 (preamble bit). Moves to TX.
- TX, WIDTH cycles:
  - `dir`=1, `data_out` = current MSB of the shift register.
  - Shift left one bit per cycle, so bits go out MSB first.
  - Bit counter ends TX after WIDTH bits; moves to TURN.
- TURN, TURN_CYCLES cycles: `dir`=0, `data_out`=0, line floats. Moves to RX if the flag is set, else DONE.
- RX, WIDTH cycles:
  - `dir`=0, `data_out`=0.
  - `data_in` is sampled at the rising edge that ends each RX cycle and shifted into the receive register, MSB first.
  - Moves to DONE.
- DONE, 1 cycle:
  - `done`=1.
  - If the flag is set, `rd_data` is updated with the receive register and `rd_valid`=1.
  - Moves to IDLE.
- Whenever `dir`=0, `data_out` is forced to 0.
- `start` outside IDLE is ignored. Captured data and flag are unchanged by `wr_data`/`rd_en` changes mid-transaction.
- A write-only transaction never modifies `rd_data`.

## Timing
- Reset values: state IDLE, `dir`=0, `data_out`=0, `busy`=0, `done`=0, `rd_valid`=0, `rd_data`=0, all counters 0.
- Reset is asynchronous: asserting `rst_n` mid-transaction forces `dir`=0 immediately, without waiting for a clock edge, and abandons the transaction. No `done` is issued.
- Cycle numbering: the `start` accept edge is edge 0; cycle k follows edge k-1.
  - PRE: cycle 1.
  - TX: cycles 2 … WIDTH+1.
  - TURN: next TURN_CYCLES cycles.
  - RX (if enabled): next WIDTH cycles.
  - DONE: final cycle.
- Busy length: write-only = 2+WIDTH+TURN_CYCLES cycles; read = 2+2·WIDTH+TURN_CYCLES cycles.
- `done` and `rd_valid` are registered outputs, high for exactly one cycle.
- `busy` falls on the edge that leaves DONE.
- `start` held high through DONE is accepted on the first IDLE cycle. Minimum spacing between transactions is therefore one IDLE cycle.

## Test plan
- Write-only, WIDTH=8, TURN_CYCLES=2, `wr_data`=0xA5, `rd_en`=0:
  - `dir`=1 in cycles 1–9, `data_out` sequence 1,1,0,1,0,0,1,0,1.
  - `dir`=0 in cycles 10–11.
  - `done`=1 in cycle 12 only, `rd_valid`=0, `rd_data` unchanged (0).
- Read, `wr_data`=0x0F, `rd_en`=1, bench drives `data_in` bits of 0x3C (MSB first) during cycles 12–19:
  - `done`=1 and `rd_valid`=1 in cycle 20.
  - `rd_data`=0x3C from cycle 20 onward.
- `start` pulsed in cycle 5 of a transaction with `wr_data`=0xFF: ignored. Serial bits still match the original word; only one `done`.
- `rst_n` low mid-TX (cycle 4), no clock edge between: `dir`=0 and `busy`=0 immediately.
  - After release, a new 0x81 write completes normally: `data_out` sequence 1,1,0,0,0,0,0,0,1.
- `start` held high continuously with `wr_data`=0x01:
  - Transactions repeat with exactly one IDLE cycle (`busy`=0, `dir`=0) between each `done` and the next PRE.
- Read of 0x5A followed by a write-only transaction: `rd_data` stays 0x5A through the second transaction and its `done`.
